// File: rtl/exe_state.sv
// Execute stage: latches the ID bundles, computes ALU/multiply/divide results,
// issues the data-SRAM request and drives the MEM result and ID forwarding buses.
module exe_state #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_EXE_valid,
  output logic        EXE_allow_in,
  input  logic [31:0] ID_pc,
  input  logic [82:0] ID_alu,
  input  logic [33:0] ID_mem,
  input  logic [5:0]  ID_rf,
  input  logic [7:0]  ID_inst,
  input  logic        MEM_allow_in,
  output logic        EXE_MEM_valid,
  output logic [31:0] EXE_pc,
  output logic [37:0] EXE_res,
  output logic [7:0]  EXE_ld,
  output logic [38:0] EXE_rf,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam logic [5:0] W_LAST = 6'(DIV_ITER - 1);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [82:0] r_alu;
  logic [33:0] r_mem;
  logic [5:0]  r_rf;
  logic [7:0]  r_inst;

  div_state_t  r_div_state, w_div_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_quot, w_quot_nxt;
  logic [31:0] r_rem, w_rem_nxt;
  logic [31:0] r_dvsr, w_dvsr_nxt;

  logic [18:0] w_op;
  logic [31:0] w_src1, w_src2;
  logic        w_is_div, w_div_signed, w_ready_go;
  logic [31:0] w_sum, w_diff, w_slt, w_sltu, w_sll, w_srl, w_sra;
  logic [4:0]  w_shamt;
  logic        w_ma_sign, w_mb_sign;
  logic [63:0] w_ma, w_mb, w_prod;
  logic [31:0] w_abs1, w_abs2;
  logic [32:0] w_trial;
  logic        w_q_neg, w_r_neg, w_dvsr_zero;
  logic [31:0] w_quot_fix, w_rem_fix, w_res;
  logic        w_mem_we, w_rfm;
  logic [31:0] w_sdata;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;

  assign w_op   = r_alu[82:64];
  assign w_src2 = r_alu[63:32];
  assign w_src1 = r_alu[31:0];

  assign w_is_div     = |w_op[18:15];
  assign w_div_signed = w_op[15] | w_op[17];
  assign w_ready_go   = ~w_is_div | (r_div_state == DIV_DONE);

  assign EXE_allow_in  = ~r_valid | (w_ready_go & MEM_allow_in);
  assign EXE_MEM_valid = r_valid & w_ready_go;

  // Pipeline register: valid bit and the bundles handed over from ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pc    <= 32'd0;
      r_alu   <= 83'd0;
      r_mem   <= 34'd0;
      r_rf    <= 6'd0;
      r_inst  <= 8'd0;
    end else begin
      if (EXE_allow_in) begin
        r_valid <= ID_EXE_valid;
      end
      if (ID_EXE_valid & EXE_allow_in) begin
        r_pc   <= ID_pc;
        r_alu  <= ID_alu;
        r_mem  <= ID_mem;
        r_rf   <= ID_rf;
        r_inst <= ID_inst;
      end
    end
  end

  assign w_sum   = w_src1 + w_src2;
  assign w_diff  = w_src1 - w_src2;
  assign w_slt   = {31'd0, ($signed(w_src1) < $signed(w_src2))};
  assign w_sltu  = {31'd0, (w_src1 < w_src2)};
  assign w_shamt = w_src2[4:0];
  assign w_sll   = w_src1 << w_shamt;
  assign w_srl   = w_src1 >> w_shamt;
  assign w_sra   = $signed(w_src1) >>> w_shamt;

  // 33-bit signed operands (zero-extended for mulh.wu), carried in 64 bits.
  assign w_ma_sign = w_op[14] ? 1'b0 : w_src1[31];
  assign w_mb_sign = w_op[14] ? 1'b0 : w_src2[31];
  assign w_ma      = {{32{w_ma_sign}}, w_src1};
  assign w_mb      = {{32{w_mb_sign}}, w_src2};
  assign w_prod    = w_ma * w_mb;

  assign w_abs1      = (w_div_signed & w_src1[31]) ? (32'd0 - w_src1) : w_src1;
  assign w_abs2      = (w_div_signed & w_src2[31]) ? (32'd0 - w_src2) : w_src2;
  assign w_trial     = {r_rem, r_quot[31]} - {1'b0, r_dvsr};
  assign w_dvsr_zero = (w_src2 == 32'd0);
  assign w_q_neg     = w_div_signed & (w_src1[31] ^ w_src2[31]);
  assign w_r_neg     = w_div_signed & w_src1[31];
  assign w_quot_fix  = w_dvsr_zero ? 32'hFFFF_FFFF : (w_q_neg ? (32'd0 - r_quot) : r_quot);
  assign w_rem_fix   = w_r_neg ? (32'd0 - r_rem) : r_rem;

  // Divider next state: load magnitudes, 32 restoring steps, hold until MEM takes it.
  always_comb begin
    w_div_state_nxt = r_div_state;
    w_cnt_nxt       = r_cnt;
    w_quot_nxt      = r_quot;
    w_rem_nxt       = r_rem;
    w_dvsr_nxt      = r_dvsr;
    case (r_div_state)
      DIV_IDLE: begin
        if (r_valid & w_is_div) begin
          w_div_state_nxt = DIV_BUSY;
          w_quot_nxt      = w_abs1;
          w_dvsr_nxt      = w_abs2;
          w_rem_nxt       = 32'd0;
          w_cnt_nxt       = 6'd0;
        end else begin
          w_div_state_nxt = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (!w_trial[32]) begin
          w_rem_nxt  = w_trial[31:0];
          w_quot_nxt = {r_quot[30:0], 1'b1};
        end else begin
          w_rem_nxt  = {r_rem[30:0], r_quot[31]};
          w_quot_nxt = {r_quot[30:0], 1'b0};
        end
        w_cnt_nxt = r_cnt + 6'd1;
        if (r_cnt == W_LAST) begin
          w_div_state_nxt = DIV_DONE;
        end else begin
          w_div_state_nxt = DIV_BUSY;
        end
      end
      DIV_DONE: begin
        if (EXE_MEM_valid & MEM_allow_in) begin
          w_div_state_nxt = DIV_IDLE;
        end else begin
          w_div_state_nxt = DIV_DONE;
        end
      end
      default: begin
        w_div_state_nxt = DIV_IDLE;
      end
    endcase
  end

  // Divider state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_state <= DIV_IDLE;
      r_cnt       <= 6'd0;
      r_quot      <= 32'd0;
      r_rem       <= 32'd0;
      r_dvsr      <= 32'd0;
    end else begin
      r_div_state <= w_div_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_quot      <= w_quot_nxt;
      r_rem       <= w_rem_nxt;
      r_dvsr      <= w_dvsr_nxt;
    end
  end

  assign w_res = ({32{w_op[0]}}  & w_sum)
               | ({32{w_op[1]}}  & w_diff)
               | ({32{w_op[2]}}  & w_slt)
               | ({32{w_op[3]}}  & w_sltu)
               | ({32{w_op[4]}}  & (w_src1 & w_src2))
               | ({32{w_op[5]}}  & ~(w_src1 | w_src2))
               | ({32{w_op[6]}}  & (w_src1 | w_src2))
               | ({32{w_op[7]}}  & (w_src1 ^ w_src2))
               | ({32{w_op[8]}}  & w_sll)
               | ({32{w_op[9]}}  & w_srl)
               | ({32{w_op[10]}} & w_sra)
               | ({32{w_op[11]}} & w_src2)
               | ({32{w_op[12]}} & w_prod[31:0])
               | ({32{w_op[13] | w_op[14]}} & w_prod[63:32])
               | ({32{w_op[15] | w_op[16]}} & w_quot_fix)
               | ({32{w_op[17] | w_op[18]}} & w_rem_fix);

  assign w_mem_we = r_mem[33];
  assign w_rfm    = r_mem[32];
  assign w_sdata  = r_mem[31:0];

  // Store byte-lane mask and replicated write data.
  always_comb begin
    w_mask  = 4'b0000;
    w_wdata = w_sdata;
    if (r_inst[5]) begin
      w_mask = 4'b1111;
    end else if (r_inst[7]) begin
      w_mask  = w_sum[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{w_sdata[15:0]}};
    end else if (r_inst[6]) begin
      w_mask  = 4'b0001 << w_sum[1:0];
      w_wdata = {4{w_sdata[7:0]}};
    end else begin
      w_mask = 4'b0000;
    end
  end

  assign data_sram_en    = r_valid & (w_mem_we | w_rfm) & MEM_allow_in;
  assign data_sram_we    = (data_sram_en & w_mem_we) ? w_mask : 4'b0000;
  assign data_sram_addr  = w_sum;
  assign data_sram_wdata = w_wdata;

  assign EXE_pc  = r_pc;
  assign EXE_res = {r_rf, w_res};
  assign EXE_ld  = {w_rfm, r_inst[4:0], w_sum[1:0]};
  assign EXE_rf  = {w_rfm & r_valid, r_rf[5] & r_valid, r_rf[4:0], w_res};

endmodule

// File: tb/tb_exe_state.sv
// Bench for exe_state: directed and random instructions checked against an
// arithmetic reference model of the ALU, multiplier and divider.
module tb_exe_state;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_EXE_valid;
  logic        EXE_allow_in;
  logic [31:0] ID_pc;
  logic [82:0] ID_alu;
  logic [33:0] ID_mem;
  logic [5:0]  ID_rf;
  logic [7:0]  ID_inst;
  logic        MEM_allow_in;
  logic        EXE_MEM_valid;
  logic [31:0] EXE_pc;
  logic [37:0] EXE_res;
  logic [7:0]  EXE_ld;
  logic [38:0] EXE_rf;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  int n_err = 0;
  int n_chk = 0;

  exe_state #(.DIV_ITER(32)) dut (
    .clk(clk), .rst(rst),
    .ID_EXE_valid(ID_EXE_valid), .EXE_allow_in(EXE_allow_in),
    .ID_pc(ID_pc), .ID_alu(ID_alu), .ID_mem(ID_mem), .ID_rf(ID_rf), .ID_inst(ID_inst),
    .MEM_allow_in(MEM_allow_in), .EXE_MEM_valid(EXE_MEM_valid),
    .EXE_pc(EXE_pc), .EXE_res(EXE_res), .EXE_ld(EXE_ld), .EXE_rf(EXE_rf),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: result of operation idx from plain integer arithmetic.
  function automatic logic [31:0] ref_alu(input int idx, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint la, lb, lp;
    longint unsigned ua, ub, up;
    logic [31:0] r;
    sa = int'(a);
    sb = int'(b);
    la = 64'(sa);
    lb = 64'(sb);
    lp = la * lb;
    ua = 64'(a);
    ub = 64'(b);
    up = ua * ub;
    case (idx)
      0: r = a + b;
      1: r = a - b;
      2: r = {31'd0, sa < sb};
      3: r = {31'd0, a < b};
      4: r = a & b;
      5: r = ~(a | b);
      6: r = a | b;
      7: r = a ^ b;
      8: r = a << b[4:0];
      9: r = a >> b[4:0];
      10: r = 32'(sa >>> b[4:0]);
      11: r = b;
      12: r = lp[31:0];
      13: r = lp[63:32];
      14: r = up[63:32];
      15: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(sa / sb);
      end
      16: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      17: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'(sa % sb);
      end
      18: r = (b == 32'd0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic mwe, input logic rfm, input logic [31:0] sd,
                       input logic [7:0] inst, input logic [4:0] rd, input logic [31:0] pc);
    logic [18:0] op;
    op = 19'd1 << idx;
    ID_alu       = {op, b, a};
    ID_mem       = {mwe, rfm, sd};
    ID_rf        = {~mwe, rd};
    ID_inst      = inst;
    ID_pc        = pc;
    ID_EXE_valid = 1'b1;
  endtask

  task automatic run_alu(input int idx, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  rd;
    logic [31:0] pc, exp;
    rd  = 5'($urandom_range(1, 31));
    pc  = $urandom;
    exp = ref_alu(idx, a, b);
    drive(idx, a, b, 1'b0, 1'b0, 32'd0, 8'd0, rd, pc);
    @(posedge clk); #1 ID_EXE_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("res op%0d %h,%h", idx, a, b), 64'(EXE_res), 64'({1'b1, rd, exp}));
    chk("mem_valid", 64'(EXE_MEM_valid), 64'd1);
    chk("fwd_bus", 64'(EXE_rf), 64'({2'b01, rd, exp}));
    chk("pc", 64'(EXE_pc), 64'(pc));
    @(posedge clk); #1;
  endtask

  // Waits out a divide already in EXE; returns at the negedge where it is ready.
  task automatic div_wait(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int stall;
    stall = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (EXE_allow_in) break;
      stall++;
    end
    chk($sformatf("div_stall op%0d", idx), 64'(stall), 64'd33);
    chk($sformatf("div_res op%0d %h,%h", idx, a, b), 64'(EXE_res), 64'({1'b1, rd, ref_alu(idx, a, b)}));
    chk("div_mem_valid", 64'(EXE_MEM_valid), 64'd1);
  endtask

  task automatic run_div(input int idx, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] rd;
    rd = 5'($urandom_range(1, 31));
    drive(idx, a, b, 1'b0, 1'b0, 32'd0, 8'd0, rd, $urandom);
    @(posedge clk); #1 ID_EXE_valid = 1'b0;
    div_wait(idx, a, b, rd);
    @(posedge clk); #1;
  endtask

  task automatic run_mem(input logic [7:0] inst, input logic mwe, input logic rfm,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                         input logic [3:0] exp_we, input logic [31:0] exp_wd);
    logic [31:0] addr;
    addr = a + b;
    drive(0, a, b, mwe, rfm, sd, inst, 5'd3, $urandom);
    @(posedge clk); #1 ID_EXE_valid = 1'b0;
    @(negedge clk);
    chk("sram_en", 64'(data_sram_en), 64'd1);
    chk($sformatf("sram_we inst=%b", inst), 64'(data_sram_we), 64'(exp_we));
    chk("sram_wdata", 64'(data_sram_wdata), 64'(exp_wd));
    chk("sram_addr", 64'(data_sram_addr), 64'(addr));
    chk("exe_ld", 64'(EXE_ld), 64'({rfm, inst[4:0], addr[1:0]}));
    chk("fwd_flags", 64'(EXE_rf[38:37]), 64'({rfm, ~mwe}));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] p1, p2;
    logic [4:0]  rd_a, rd_b;
    rst = 1'b0;
    ID_EXE_valid = 1'b0; ID_pc = 32'd0; ID_alu = 83'd0; ID_mem = 34'd0;
    ID_rf = 6'd0; ID_inst = 8'd0; MEM_allow_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_allow_in", 64'(EXE_allow_in), 64'd1);
    chk("rst_mem_valid", 64'(EXE_MEM_valid), 64'd0);
    chk("rst_sram_en", 64'(data_sram_en), 64'd0);
    chk("rst_sram_we", 64'(data_sram_we), 64'd0);
    chk("rst_fwd_flags", 64'(EXE_rf[38:37]), 64'd0);
    chk("rst_res", 64'(EXE_res), 64'd0);
    chk("rst_pc", 64'(EXE_pc), 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    run_alu(0, 32'd5, 32'd7);
    run_div(15, 32'hFFFF_FFF9, 32'd2);
    run_div(17, 32'hFFFF_FFF9, 32'd2);
    run_div(16, 32'd7, 32'd0);
    run_div(15, 32'hFFFF_FFF9, 32'd0);
    run_div(17, 32'hFFFF_FFF9, 32'd0);
    run_div(15, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(17, 32'h8000_0000, 32'hFFFF_FFFF);
    run_alu(14, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_alu(13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_alu(12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_alu(10, 32'h8000_0000, 32'd31);

    for (int i = 0; i < 50; i++) begin
      run_alu($urandom_range(0, 14), pick(), pick());
    end
    for (int i = 0; i < 8; i++) begin
      run_div($urandom_range(15, 18), pick(), pick());
    end

    run_mem(8'b0100_0000, 1'b1, 1'b0, 32'h1000, 32'd3, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
    run_mem(8'b1000_0000, 1'b1, 1'b0, 32'h1000, 32'd2, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    run_mem(8'b1000_0000, 1'b1, 1'b0, 32'h1000, 32'd0, 32'h0000_5678, 4'b0011, 32'h5678_5678);
    run_mem(8'b0010_0000, 1'b1, 1'b0, 32'h2000, 32'd4, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    run_mem(8'b0000_1000, 1'b0, 1'b1, 32'h3000, 32'd1, 32'h0000_0000, 4'b0000, 32'h0000_0000);

    // Back-to-back divides: second enters on the edge the first leaves.
    rd_a = 5'd9; rd_b = 5'd10;
    drive(16, 32'd1000, 32'd7, 1'b0, 1'b0, 32'd0, 8'd0, rd_a, 32'h100);
    @(posedge clk); #1 ID_EXE_valid = 1'b0;
    div_wait(16, 32'd1000, 32'd7, rd_a);
    drive(18, 32'd1000, 32'd7, 1'b0, 1'b0, 32'd0, 8'd0, rd_b, 32'h104);
    @(posedge clk); #1 ID_EXE_valid = 1'b0;
    div_wait(18, 32'd1000, 32'd7, rd_b);
    @(posedge clk); #1;

    // Backpressure from MEM with a second instruction waiting in ID.
    p1 = 32'h0000_4000; p2 = 32'h0000_4004;
    MEM_allow_in = 1'b0;
    drive(0, 32'h40, 32'd0, 1'b1, 1'b0, 32'h55, 8'b0010_0000, 5'd0, p1);
    @(posedge clk); #1;
    drive(0, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0, 8'd0, 5'd4, p2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_allow_in", 64'(EXE_allow_in), 64'd0);
      chk("bp_sram_en", 64'(data_sram_en), 64'd0);
      chk("bp_sram_we", 64'(data_sram_we), 64'd0);
      chk("bp_pc_stable", 64'(EXE_pc), 64'(p1));
      chk("bp_addr_stable", 64'(data_sram_addr), 64'h40);
    end
    MEM_allow_in = 1'b1;
    #1;
    chk("rel_allow_in", 64'(EXE_allow_in), 64'd1);
    chk("rel_sram_we", 64'(data_sram_we), 64'hF);
    @(posedge clk); #1 ID_EXE_valid = 1'b0;
    @(negedge clk);
    chk("rel_next_pc", 64'(EXE_pc), 64'(p2));
    chk("rel_next_res", 64'(EXE_res), 64'({1'b1, 5'd4, 32'd3}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_drained", 64'(EXE_MEM_valid), 64'd0);

    // Reset in the middle of a divide, then a fresh divide.
    drive(16, 32'd100, 32'd3, 1'b0, 1'b0, 32'd0, 8'd0, 5'd7, 32'h200);
    @(posedge clk); #1 ID_EXE_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_mem_valid", 64'(EXE_MEM_valid), 64'd0);
    chk("mid_rst_allow_in", 64'(EXE_allow_in), 64'd1);
    chk("mid_rst_fwd_flags", 64'(EXE_rf[38:37]), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    run_div(16, 32'd100, 32'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
